// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes and types for the LC-3 register-file write scheduler.
//   REG_W    register width (16)
//   RADDR_W  register address width (3)
//   NREG     number of registers (8)
//   wr_bundle_t  one requester's write (destination register + data)
package regfile_pkg;
    localparam int REG_W   = 16;
    localparam int RADDR_W = 3;
    localparam int NREG    = 8;

    typedef struct packed {
        logic [RADDR_W-1:0] dr;
        logic [REG_W-1:0]   data;
    } wr_bundle_t;
endpackage

// File: rtl/regwr_arbiter.sv
// regwr_arbiter: picks one write requester per cycle for the register-file
// write port.
//   REGWR_RR_EN defined   : round-robin; the pointer holds the last granted index
//                           and the search starts at pointer+1 (mod NREQ).
//   REGWR_RR_EN undefined : fixed priority, lowest index wins; no pointer state.
// Ports:
//   clk, reset   clock and asynchronous active-low reset (pointer only)
//   req_valid    per-requester write pending
//   xfer         a grant was taken this cycle (pointer advance strobe)
//   grant        one-hot grant, only ever set for a valid requester
module regwr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_valid,
    input  logic            xfer,
    output logic [NREQ-1:0] grant
);

`ifdef REGWR_RR_EN
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;

    // Scan positions ptr+1, ptr+2, ... in order; the first valid requester wins.
    always_comb begin
        logic        found;
        int unsigned start;
        grant = '0;
        gidx  = ptr;
        found = 1'b0;
        start = (int unsigned'(ptr) + 1) % NREQ;
        for (int unsigned k = 0; k < NREQ; k++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!found && req_valid[i] && (i == (start + k) % NREQ)) begin
                    grant[i] = 1'b1;
                    gidx     = PW'(i);
                    found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= PW'(NREQ - 1);
        end else if (xfer) begin
            ptr <= gidx;
        end
    end
`else
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    logic unused_rr;
    assign unused_rr = ^{clk, reset, xfer};
`endif

endmodule

// File: rtl/regfile_wr_sched.sv
// regfile_wr_sched: shares the LC-3 register file's single write port among
// NREQ result sources and keeps a per-register pending-write scoreboard.
// Optional feature macro: REGWR_RR_EN (round-robin arbitration; fixed priority
// when undefined).
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   req_valid/dr/data    per-requester write request (held until granted)
//   req_ready            one-hot grant (combinational from req_valid)
//   rsv_valid/rsv_dr     reserve a destination register at issue
//   rsv_ready            reservation accepted (register not already busy)
//   SR1, SR2             source registers queried
//   sr1_busy, sr2_busy   source has a pending write (no bypass)
//   regWE, DR, Buss      registered register-file write port
module regfile_wr_sched
    import regfile_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ-1:0][RADDR_W-1:0]  req_dr,
    input  logic [NREQ-1:0][REG_W-1:0]    req_data,
    output logic [NREQ-1:0]               req_ready,
    input  logic                          rsv_valid,
    input  logic [RADDR_W-1:0]            rsv_dr,
    output logic                          rsv_ready,
    input  logic [RADDR_W-1:0]            SR1,
    input  logic [RADDR_W-1:0]            SR2,
    output logic                          sr1_busy,
    output logic                          sr2_busy,
    output logic                          regWE,
    output logic [RADDR_W-1:0]            DR,
    output logic [REG_W-1:0]              Buss
);

    logic [NREQ-1:0] grant;
    logic            xfer;
    wr_bundle_t      sel;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    regwr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .xfer     (xfer),
        .grant    (grant)
    );

    // The arbiter only grants valid requesters, so any grant is a transfer.
    assign req_ready = grant;
    assign xfer      = |grant;

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel.dr   = req_dr[i];
                sel.data = req_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regWE <= 1'b0;
            DR    <= '0;
            Buss  <= '0;
        end else begin
            regWE <= xfer;
            if (xfer) begin
                DR   <= sel.dr;
                Buss <= sel.data;
            end
        end
    end

    assign rsv_ready = ~busy[rsv_dr];
    assign sr1_busy  = busy[SR1];
    assign sr2_busy  = busy[SR2];

    // Clear first, then set: a reservation landing on a register whose
    // (unreserved) write is retiring this cycle must stay reserved.
    always_comb begin
        busy_next = busy;
        if (regWE) begin
            busy_next[DR] = 1'b0;
        end
        if (rsv_valid && rsv_ready) begin
            busy_next[rsv_dr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_wr_sched.sv
module tb_regfile_wr_sched;

    localparam int NREQ = 3;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0][2:0]  req_dr;
    logic [NREQ-1:0][15:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  rsv_valid;
    logic [2:0]            rsv_dr;
    logic                  rsv_ready;
    logic [2:0]            SR1;
    logic [2:0]            SR2;
    logic                  sr1_busy;
    logic                  sr2_busy;
    logic                  regWE;
    logic [2:0]            DR;
    logic [15:0]           Buss;

    int checks = 0;
    int errors = 0;

    regfile_wr_sched #(
        .NREQ(NREQ)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_dr   (req_dr),
        .req_data (req_data),
        .req_ready(req_ready),
        .rsv_valid(rsv_valid),
        .rsv_dr   (rsv_dr),
        .rsv_ready(rsv_ready),
        .SR1      (SR1),
        .SR2      (SR2),
        .sr1_busy (sr1_busy),
        .sr2_busy (sr2_busy),
        .regWE    (regWE),
        .DR       (DR),
        .Buss     (Buss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  v;
        logic [2:0]  dr;
        logic [15:0] data;
        logic        rv;
        logic [2:0]  rdr;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [2:0]  e_rdy;
        logic        e_rsv;
        logic        e_b1;
        logic        e_b2;
        logic        e_we;
        logic [2:0]  e_dr;
        logic [15:0] e_buss;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] v, input logic [2:0] dr, input logic [15:0] data,
                                input logic rv, input logic [2:0] rdr, input logic [2:0] s1,
                                input logic [2:0] s2, input logic [2:0] e_rdy, input logic e_rsv,
                                input logic e_b1, input logic e_b2, input logic e_we,
                                input logic [2:0] e_dr, input logic [15:0] e_buss);
        vec_t r;
        r.v = v; r.dr = dr; r.data = data; r.rv = rv; r.rdr = rdr; r.s1 = s1; r.s2 = s2;
        r.e_rdy = e_rdy; r.e_rsv = e_rsv; r.e_b1 = e_b1; r.e_b2 = e_b2;
        r.e_we = e_we; r.e_dr = e_dr; r.e_buss = e_buss;
        return r;
    endfunction

    // Reference model: specification-level arbitration rule.
    function automatic int pick(input logic [2:0] v, input int last);
`ifdef REGWR_RR_EN
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last + k) % NREQ;
            if (v[c]) return c;
        end
        return -1;
`else
        for (int c = 0; c < NREQ; c++) begin
            if (v[c]) return c;
        end
        return -1;
`endif
    endfunction

    vec_t tbl[16];

    bit          mbusy[8];
    int          mlast;
    bit          mwe;
    logic [2:0]  mdr;
    logic [15:0] mdata;
    bit          pv[NREQ];
    logic [2:0]  pdr[NREQ];
    logic [15:0] pdata[NREQ];

    initial begin
        //           v     dr    data      rv    rdr   s1    s2    rdy   rsv   b1    b2    we    DR    Buss
        tbl[0]  = mk(3'b000, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
        tbl[1]  = mk(3'b001, 3'd3, 16'h1234, 1'b0, 3'd0, 3'd0, 3'd0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
        tbl[2]  = mk(3'b000, 3'd3, 16'h1234, 1'b0, 3'd0, 3'd0, 3'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 16'h1234);
        tbl[3]  = mk(3'b000, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd3, 3'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 16'h1234);
        tbl[4]  = mk(3'b000, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd5, 3'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 16'h1234);
        tbl[5]  = mk(3'b000, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd5, 3'd5, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 16'h1234);
        tbl[6]  = mk(3'b001, 3'd5, 16'h5555, 1'b0, 3'd5, 3'd5, 3'd0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 16'h1234);
        tbl[7]  = mk(3'b000, 3'd5, 16'h5555, 1'b0, 3'd5, 3'd5, 3'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 16'h5555);
        tbl[8]  = mk(3'b000, 3'd0, 16'h0000, 1'b0, 3'd5, 3'd5, 3'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 16'h5555);
        tbl[9]  = mk(3'b000, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd4, 3'd5, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 16'h5555);
        tbl[10] = mk(3'b001, 3'd4, 16'h4444, 1'b0, 3'd4, 3'd4, 3'd5, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 16'h5555);
        tbl[11] = mk(3'b000, 3'd4, 16'h4444, 1'b1, 3'd2, 3'd4, 3'd2, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 16'h4444);
        tbl[12] = mk(3'b000, 3'd0, 16'h0000, 1'b0, 3'd2, 3'd4, 3'd2, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 16'h4444);
        tbl[13] = mk(3'b001, 3'd6, 16'hBEEF, 1'b0, 3'd6, 3'd6, 3'd2, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 16'h4444);
        tbl[14] = mk(3'b000, 3'd6, 16'hBEEF, 1'b0, 3'd6, 3'd6, 3'd2, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 16'hBEEF);
        tbl[15] = mk(3'b000, 3'd0, 16'h0000, 1'b0, 3'd6, 3'd6, 3'd2, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 16'hBEEF);

        reset     = 1'b0;
        req_valid = '0;
        req_dr    = '0;
        req_data  = '0;
        rsv_valid = 1'b0;
        rsv_dr    = '0;
        SR1       = '0;
        SR2       = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Directed table: reset state, single write, scoreboard, same-cycle set/clear, unreserved write.
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            req_valid = tbl[k].v;
            req_dr    = {NREQ{tbl[k].dr}};
            req_data  = {NREQ{tbl[k].data}};
            rsv_valid = tbl[k].rv;
            rsv_dr    = tbl[k].rdr;
            SR1       = tbl[k].s1;
            SR2       = tbl[k].s2;
            #1;
            chk($sformatf("tbl%0d_req_ready", k), 32'(req_ready), 32'(tbl[k].e_rdy));
            chk($sformatf("tbl%0d_rsv_ready", k), 32'(rsv_ready), 32'(tbl[k].e_rsv));
            chk($sformatf("tbl%0d_sr1_busy", k),  32'(sr1_busy),  32'(tbl[k].e_b1));
            chk($sformatf("tbl%0d_sr2_busy", k),  32'(sr2_busy),  32'(tbl[k].e_b2));
            chk($sformatf("tbl%0d_regWE", k),     32'(regWE),     32'(tbl[k].e_we));
            chk($sformatf("tbl%0d_DR", k),        32'(DR),        32'(tbl[k].e_dr));
            chk($sformatf("tbl%0d_Buss", k),      32'(Buss),      32'(tbl[k].e_buss));
        end

        // Reset mid-stream: grant, then assert reset while the write is on the port.
        @(negedge clk);
        rsv_valid = 1'b0;
        req_valid = 3'b001;
        req_dr    = {3'd0, 3'd0, 3'd3};
        req_data  = {16'h0, 16'h0, 16'h7777};
        SR1       = 3'd2;
        rsv_dr    = 3'd2;
        #1;
        chk("mid_grant", 32'(req_ready), 32'h1);
        chk("mid_busy_before", 32'(sr1_busy), 32'h1);
        @(posedge clk);
        #2;
        chk("mid_we_before", 32'(regWE), 32'h1);
        reset     = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_regWE", 32'(regWE), 32'h0);
        chk("rst_DR", 32'(DR), 32'h0);
        chk("rst_Buss", 32'(Buss), 32'h0);
        chk("rst_busy", 32'(sr1_busy), 32'h0);
        chk("rst_rsv_ready", 32'(rsv_ready), 32'h1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // All three requesters valid for six cycles.
        begin
            logic [2:0]  drs[3];
            logic [15:0] dats[3];
            int          prev;
            drs[0] = 3'd1; drs[1] = 3'd2; drs[2] = 3'd7;
            dats[0] = 16'hC000; dats[1] = 16'hC001; dats[2] = 16'hC002;
            req_valid = 3'b111;
            req_dr    = {drs[2], drs[1], drs[0]};
            req_data  = {dats[2], dats[1], dats[0]};
            prev = -1;
            for (int c = 0; c < 6; c++) begin
                int gi;
`ifdef REGWR_RR_EN
                gi = c % 3;
`else
                gi = 0;
`endif
                #1;
                chk($sformatf("all_grant%0d", c), 32'(req_ready), 32'(1 << gi));
                if (prev < 0) begin
                    chk($sformatf("all_we%0d", c), 32'(regWE), 32'h0);
                end else begin
                    chk($sformatf("all_we%0d", c), 32'(regWE), 32'h1);
                    chk($sformatf("all_dr%0d", c), 32'(DR), 32'(drs[prev]));
                    chk($sformatf("all_buss%0d", c), 32'(Buss), 32'(dats[prev]));
                end
                prev = gi;
                @(negedge clk);
            end
            req_valid = '0;
            #1;
            chk("all_we_last", 32'(regWE), 32'h1);
            chk("all_dr_last", 32'(DR), 32'(drs[prev]));
        end

        // Randomized run against the reference model, from a fresh reset.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int r = 0; r < 8; r++) mbusy[r] = 1'b0;
        mlast = NREQ - 1;
        mwe   = 1'b0;
        mdr   = '0;
        mdata = '0;
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;

        for (int c = 0; c < 400; c++) begin
            int         g;
            bit         acc;
            logic [2:0] vv;
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && ($urandom_range(0, 99) < 50)) begin
                    pv[i]    = 1'b1;
                    pdr[i]   = 3'($urandom_range(0, 7));
                    pdata[i] = 16'($urandom);
                end
                vv[i]       = pv[i];
                req_dr[i]   = pdr[i];
                req_data[i] = pdata[i];
            end
            req_valid = vv;
            rsv_valid = ($urandom_range(0, 99) < 40);
            rsv_dr    = 3'($urandom_range(0, 7));
            SR1       = 3'($urandom_range(0, 7));
            SR2       = 3'($urandom_range(0, 7));
            #1;
            g = pick(vv, mlast);
            chk("rnd_req_ready", 32'(req_ready), (g < 0) ? 32'h0 : 32'(1 << g));
            chk("rnd_rsv_ready", 32'(rsv_ready), 32'(!mbusy[rsv_dr]));
            chk("rnd_sr1_busy", 32'(sr1_busy), 32'(mbusy[SR1]));
            chk("rnd_sr2_busy", 32'(sr2_busy), 32'(mbusy[SR2]));
            chk("rnd_regWE", 32'(regWE), 32'(mwe));
            chk("rnd_DR", 32'(DR), 32'(mdr));
            chk("rnd_Buss", 32'(Buss), 32'(mdata));
            acc = rsv_valid && !mbusy[rsv_dr];
            if (mwe) mbusy[mdr] = 1'b0;
            if (acc) mbusy[rsv_dr] = 1'b1;
            if (g >= 0) begin
                mwe   = 1'b1;
                mdr   = pdr[g];
                mdata = pdata[g];
                pv[g] = 1'b0;
                mlast = g;
            end else begin
                mwe = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
